// File: rtl/ascon_pkg.sv
// Shared Ascon types, FSM encoding, round constant and rotation helpers.
package ascon_pkg;

  // x0..x4, x[i] holds state word i
  typedef logic [4:0][63:0] ascon_state_t;
  // {K0, K1}
  typedef logic [127:0]     ascon_key_t;

  typedef enum logic [0:0] {
    FSM_IDLE = 1'b0,
    FSM_BUSY = 1'b1
  } fsm_t;

  // Linear-layer rotate-right amounts, two per word
  localparam int unsigned ROT_X0_A = 19;
  localparam int unsigned ROT_X0_B = 28;
  localparam int unsigned ROT_X1_A = 61;
  localparam int unsigned ROT_X1_B = 39;
  localparam int unsigned ROT_X2_A = 1;
  localparam int unsigned ROT_X2_B = 6;
  localparam int unsigned ROT_X3_A = 10;
  localparam int unsigned ROT_X3_B = 17;
  localparam int unsigned ROT_X4_A = 7;
  localparam int unsigned ROT_X4_B = 41;

  // Round constant for absolute constant index i (0..11)
  function automatic logic [7:0] round_const(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

  // 64-bit rotate right; amounts are always 1..63 here
  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon permutation round: constant add, S-box, linear layer.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  input  logic [3:0]   round_idx_i,
  output ascon_state_t state_o
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  // Bit-sliced round evaluated in place on the five words
  always_comb begin
    x0 = state_i[0];
    x1 = state_i[1];
    x2 = state_i[2] ^ {56'd0, round_const(round_idx_i)};
    x3 = state_i[3];
    x4 = state_i[4];
    // S-box input mixing
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    // Chi-like core
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    // S-box output mixing
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    // Linear diffusion
    state_o[0] = x0 ^ ror64(x0, ROT_X0_A) ^ ror64(x0, ROT_X0_B);
    state_o[1] = x1 ^ ror64(x1, ROT_X1_A) ^ ror64(x1, ROT_X1_B);
    state_o[2] = x2 ^ ror64(x2, ROT_X2_A) ^ ror64(x2, ROT_X2_B);
    state_o[3] = x3 ^ ror64(x3, ROT_X3_A) ^ ror64(x3, ROT_X3_B);
    state_o[4] = x4 ^ ror64(x4, ROT_X4_A) ^ ror64(x4, ROT_X4_B);
  end

endmodule

// File: rtl/ascon_final.sv
// Ascon AEAD finalization: key XOR, ROUNDS permutation rounds, tag form/compare.
//
// Handshake: start_i is a one-cycle request with no ready; it is taken only
// when the FSM is IDLE (busy_o low) and dropped otherwise. Completion is the
// one-cycle finished_o/intr_o pulse; tag_o, tag_match_o and state_o are
// valid from that cycle and hold until the next completion.
module ascon_final
  import ascon_pkg::*;
#(
  parameter int ROUNDS     = 12,
  parameter int RATE_WORDS = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         decrypt_i,
  input  ascon_key_t   key_i,
  input  ascon_state_t state_i,
  input  logic [127:0] tag_i,
  output logic         busy_o,
  output logic         finished_o,
  output logic [127:0] tag_o,
  output logic         tag_match_o,
  output ascon_state_t state_o,
  output logic         intr_o,
  output fsm_t         fsm_state_o
);

  localparam logic [3:0] LAST_CNT  = 4'(ROUNDS - 1);
  localparam logic [3:0] CONST_OFS = 4'(12 - ROUNDS);

  fsm_t         fsm_q;
  logic [3:0]   cnt_q;
  ascon_state_t state_q;
  ascon_key_t   key_q;
  logic [127:0] tag_q;
  logic         dec_q;

  ascon_state_t load_state;
  ascon_state_t round_next;
  logic [3:0]   round_idx;
  logic [127:0] tag_next;

  // Reduced-round variants use the last ROUNDS constants of the 12-round schedule
  assign round_idx = cnt_q + CONST_OFS;

  ascon_round u_round (
    .state_i     (state_q),
    .round_idx_i (round_idx),
    .state_o     (round_next)
  );

  // Initial state: key folded into the two words just past the rate
  always_comb begin
    load_state                 = state_i;
    load_state[RATE_WORDS]     = state_i[RATE_WORDS] ^ key_i[127:64];
    load_state[RATE_WORDS + 1] = state_i[RATE_WORDS + 1] ^ key_i[63:0];
  end

  // Tag taken from the state the final round produces
  assign tag_next = {round_next[3] ^ key_q[127:64], round_next[4] ^ key_q[63:0]};

  // FSM, round counter, latches and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q       <= FSM_IDLE;
      cnt_q       <= 4'd0;
      state_q     <= '0;
      key_q       <= '0;
      tag_q       <= '0;
      dec_q       <= 1'b0;
      finished_o  <= 1'b0;
      tag_o       <= '0;
      tag_match_o <= 1'b0;
      state_o     <= '0;
    end else begin
      finished_o <= 1'b0;
      case (fsm_q)
        FSM_IDLE: begin
          if (start_i) begin
            key_q   <= key_i;
            tag_q   <= tag_i;
            dec_q   <= decrypt_i;
            state_q <= load_state;
            cnt_q   <= 4'd0;
            fsm_q   <= FSM_BUSY;
          end
        end
        FSM_BUSY: begin
          state_q <= round_next;
          cnt_q   <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            state_o     <= round_next;
            tag_o       <= tag_next;
            tag_match_o <= dec_q && (tag_next == tag_q);
            finished_o  <= 1'b1;
            fsm_q       <= FSM_IDLE;
          end
        end
        default: fsm_q <= FSM_IDLE;
      endcase
    end
  end

  assign busy_o      = (fsm_q == FSM_BUSY);
  assign intr_o      = finished_o;
  assign fsm_state_o = fsm_q;

endmodule

// File: tb/tb_ascon_final.sv
// Bench for ascon_final: Ascon-128 (12 rounds, rate 1) and a 6-round rate-2 instance.
module tb_ascon_final;
  import ascon_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start_a, start_b, decrypt;
  ascon_key_t   key;
  ascon_state_t state_in;
  logic [127:0] tag_in;

  logic         busy_a, fin_a, match_a, intr_a, busy_b, fin_b, match_b, intr_b;
  logic [127:0] tag_a, tag_b;
  ascon_state_t st_a, st_b;
  fsm_t         fsm_a, fsm_b;

  ascon_final #(.ROUNDS(12), .RATE_WORDS(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .decrypt_i(decrypt), .key_i(key),
    .state_i(state_in), .tag_i(tag_in), .busy_o(busy_a), .finished_o(fin_a),
    .tag_o(tag_a), .tag_match_o(match_a), .state_o(st_a), .intr_o(intr_a),
    .fsm_state_o(fsm_a));

  ascon_final #(.ROUNDS(6), .RATE_WORDS(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .decrypt_i(decrypt), .key_i(key),
    .state_i(state_in), .tag_i(tag_in), .busy_o(busy_b), .finished_o(fin_b),
    .tag_o(tag_b), .tag_match_o(match_b), .state_o(st_b), .intr_o(intr_b),
    .fsm_state_o(fsm_b));

  // selected instance view
  int           sel;
  logic         busy, fin, match, intr;
  logic [127:0] tag_o;
  ascon_state_t st_o;
  always_comb begin
    if (sel == 1) begin
      busy = busy_b; fin = fin_b; match = match_b; intr = intr_b; tag_o = tag_b; st_o = st_b;
    end else begin
      busy = busy_a; fin = fin_a; match = match_a; intr = intr_a; tag_o = tag_a; st_o = st_a;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam logic [4:0] SBOX [0:31] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  function automatic logic [63:0] m_ror(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  // S-box applied column by column from the lookup table (x0 is the MSB)
  function automatic ascon_state_t m_round(input ascon_state_t s, input int i);
    ascon_state_t t;
    logic [4:0]   col, o;
    s[2] = s[2] ^ {56'd0, 4'(15 - i), 4'(i)};
    for (int b = 0; b < 64; b++) begin
      col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
      o   = SBOX[col];
      t[0][b] = o[4]; t[1][b] = o[3]; t[2][b] = o[2]; t[3][b] = o[1]; t[4][b] = o[0];
    end
    t[0] = t[0] ^ m_ror(t[0], 19) ^ m_ror(t[0], 28);
    t[1] = t[1] ^ m_ror(t[1], 61) ^ m_ror(t[1], 39);
    t[2] = t[2] ^ m_ror(t[2], 1)  ^ m_ror(t[2], 6);
    t[3] = t[3] ^ m_ror(t[3], 10) ^ m_ror(t[3], 17);
    t[4] = t[4] ^ m_ror(t[4], 7)  ^ m_ror(t[4], 41);
    return t;
  endfunction

  function automatic void m_final(input ascon_state_t s_in, input ascon_key_t k, input int rounds,
                                  input int rate, output ascon_state_t perm, output logic [127:0] tg);
    ascon_state_t s;
    s = s_in;
    s[rate]     = s[rate] ^ k[127:64];
    s[rate + 1] = s[rate + 1] ^ k[63:0];
    for (int r = 0; r < rounds; r++) s = m_round(s, r + 12 - rounds);
    perm = s;
    tg   = {s[3] ^ k[127:64], s[4] ^ k[63:0]};
  endfunction

  // Ascon-128 init + empty AD + empty plaintext, giving the pre-finalization state
  function automatic ascon_state_t m_pre_final(input ascon_key_t k, input logic [127:0] n);
    ascon_state_t s;
    s[0] = 64'h80400c0600000000;
    s[1] = k[127:64]; s[2] = k[63:0]; s[3] = n[127:64]; s[4] = n[63:0];
    for (int i = 0; i < 12; i++) s = m_round(s, i);
    s[3] = s[3] ^ k[127:64];
    s[4] = s[4] ^ k[63:0];
    s[4] = s[4] ^ 64'h1;
    s[0] = s[0] ^ 64'h8000000000000000;
    return s;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- driver ----------------
  // Starts one operation on instance `which` and waits for finished; returns at
  // the negedge where finished is high. now=1 starts in the current cycle.
  task automatic run_op(input int which, input logic now, input logic dec, input ascon_key_t k,
                        input ascon_state_t s, input logic [127:0] t,
                        output int lat, output int busy_cnt);
    int intr_bad;
    sel = which;
    if (!now) @(negedge clk);
    decrypt = dec; key = k; state_in = s; tag_in = t;
    if (which == 1) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    // inputs are don't-care once sampled
    decrypt = 1'($urandom); key = {rnd64(), rnd64()};
    state_in = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()}; tag_in = {rnd64(), rnd64()};
    lat = 1; busy_cnt = 0; intr_bad = 0;
    while (!fin && lat < 60) begin
      if (busy) busy_cnt++;
      if (intr !== fin) intr_bad++;
      @(negedge clk);
      lat++;
    end
    if (intr !== fin) intr_bad++;
    check("finish_seen", 320'(fin), 320'(1));
    check("intr_eq_fin", 320'(intr_bad), 320'(0));
  endtask

  // ---------------- stimulus ----------------
  ascon_key_t   kat_key;
  logic [127:0] kat_nonce, exp_tag, exp_tag2;
  ascon_state_t kat_state, exp_st, s2;
  int           lat, bc, fin_cnt, fin_at;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; decrypt = 1'b0;
    key = '0; state_in = '0; tag_in = '0; sel = 0;

    // 1. reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   320'(busy_a),  320'(0));
    check("rst_fin",    320'(fin_a),   320'(0));
    check("rst_tag",    320'(tag_a),   320'(0));
    check("rst_match",  320'(match_a), 320'(0));
    check("rst_state",  320'(st_a),    320'(0));
    check("rst_fsm",    320'(fsm_a),   320'(FSM_IDLE));
    check("rst_b_tag",  320'(tag_b),   320'(0));
    rst = 1'b0;
    @(negedge clk);
    key = {rnd64(), rnd64()}; state_in = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 320'(busy_a), 320'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_idle", 320'(busy_a), 320'(0));
    check("abort_fsm",  320'(fsm_a),  320'(FSM_IDLE));
    fin_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (fin_a) fin_cnt++;
    end
    check("abort_no_finish", 320'(fin_cnt), 320'(0));
    check("abort_tag_clear", 320'(tag_a),   320'(0));

    // 2/3. latency and encrypt KAT
    kat_key   = 128'h000102030405060708090A0B0C0D0E0F;
    kat_nonce = 128'h000102030405060708090A0B0C0D0E0F;
    kat_state = m_pre_final(kat_key, kat_nonce);
    m_final(kat_state, kat_key, 12, 1, exp_st, exp_tag);
    run_op(0, 1'b0, 1'b0, kat_key, kat_state, '0, lat, bc);
    check("kat_latency", 320'(lat), 320'(13));
    check("kat_busy_cycles", 320'(bc), 320'(12));
    check("kat_tag",   320'(tag_o), 320'(exp_tag));
    check("kat_state", st_o, exp_st);
    check("kat_match_enc", 320'(match), 320'(0));
    @(negedge clk);
    check("fin_one_cycle", 320'(fin),   320'(0));
    check("tag_held",      320'(tag_o), 320'(exp_tag));

    // 4. decrypt, good and bad tag
    run_op(0, 1'b0, 1'b1, kat_key, kat_state, exp_tag, lat, bc);
    check("dec_match_good", 320'(match), 320'(1));
    check("dec_tag_good",   320'(tag_o), 320'(exp_tag));
    run_op(0, 1'b0, 1'b1, kat_key, kat_state, exp_tag ^ 128'h1, lat, bc);
    check("dec_match_bad", 320'(match), 320'(0));
    check("dec_tag_bad",   320'(tag_o), 320'(exp_tag));

    // 5. back-to-back start in the finished cycle
    s2 = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
    m_final(s2, kat_key, 12, 1, exp_st, exp_tag2);
    run_op(0, 1'b1, 1'b0, kat_key, s2, '0, lat, bc);
    check("b2b_latency", 320'(lat),   320'(13));
    check("b2b_tag",     320'(tag_o), 320'(exp_tag2));

    // 5b. start pulses while busy are dropped
    @(negedge clk);
    sel = 0; decrypt = 1'b0; key = kat_key; state_in = kat_state; start_a = 1'b1;
    fin_cnt = 0; fin_at = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start_a = (c == 3 || c == 8);
      state_in = s2;
      if (fin_a) begin
        fin_cnt++;
        if (fin_at == 0) fin_at = c;
        check("ignore_tag", 320'(tag_a), 320'(exp_tag));
      end
    end
    start_a = 1'b0;
    check("ignore_single_finish", 320'(fin_cnt), 320'(1));
    check("ignore_latency",       320'(fin_at),  320'(13));

    // 6. 6-round rate-2 instance
    m_final(kat_state, kat_key, 6, 2, exp_st, exp_tag);
    run_op(1, 1'b0, 1'b0, kat_key, kat_state, '0, lat, bc);
    check("p2_latency", 320'(lat),   320'(7));
    check("p2_busy",    320'(bc),    320'(6));
    check("p2_tag",     320'(tag_o), 320'(exp_tag));
    check("p2_state",   st_o, exp_st);
    run_op(1, 1'b0, 1'b1, kat_key, kat_state, exp_tag, lat, bc);
    check("p2_match", 320'(match), 320'(1));

    // random sweep over both instances and both modes
    for (int v = 0; v < 1000; v++) begin
      int           w;
      logic         dec, good;
      ascon_key_t   k;
      ascon_state_t s;
      logic [127:0] t;
      w = v % 2;
      dec = 1'($urandom_range(0, 1));
      good = 1'($urandom_range(0, 1));
      k = {rnd64(), rnd64()};
      s = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
      m_final(s, k, (w == 1) ? 6 : 12, (w == 1) ? 2 : 1, exp_st, exp_tag);
      t = good ? exp_tag : {rnd64(), rnd64()};
      run_op(w, 1'b0, dec, k, s, t, lat, bc);
      check("rnd_latency", 320'(lat), 320'((w == 1) ? 7 : 13));
      check("rnd_tag",     320'(tag_o), 320'(exp_tag));
      check("rnd_state",   st_o, exp_st);
      check("rnd_match",   320'(match), 320'(dec && (t == exp_tag)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
